button_debounce_pulse: RTL and testbench



---
 rtl/button_pkg.sv | 18 +
 rtl/btn_debounce_ch.sv | 87 ++++++++
 rtl/button_debounce_pulse.sv | 59 +++++
 tb/tb_button_debounce_pulse.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and constants for the push-button debounce front end.
package button_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;

  // Width needed to hold 0..cycles; never collapses to a zero-width vector.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, stable-count filter FSM,
// single-cycle press strobe and registered debounced level.
module btn_debounce_ch
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic strobe_o,
  output logic level_o
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          s;
  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;

  assign s = sync_q[1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    strobe_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (s) state_d = ST_PRESS_WAIT;
      end
      ST_PRESS_WAIT: begin
        if (!s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_PRESSED;
          cnt_d    = '0;
          strobe_o = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_PRESSED: begin
        cnt_d = '0;
        if (!s) state_d = ST_RELEASE_WAIT;
      end
      ST_RELEASE_WAIT: begin
        // A bounce back to 1 returns to PRESSED without a new strobe.
        if (s) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q  <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/button_debounce_pulse.sv
// Debounced push-button front end: per-channel filters feeding a pending
// register and an optional lowest-index-first one-hot pulse arbiter.
module button_debounce_pulse
  import button_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned ONE_HOT_PULSE   = 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [NUM_BUTTONS-1:0] i_button_raw,
  output logic [NUM_BUTTONS-1:0] o_button_pulse,
  output logic [NUM_BUTTONS-1:0] o_button_level
);

  logic [NUM_BUTTONS-1:0] strobe;
  logic [NUM_BUTTONS-1:0] level;
  logic [NUM_BUTTONS-1:0] pending_q, pending_d;
  logic [NUM_BUTTONS-1:0] pulse_q, pulse_d;
  logic [NUM_BUTTONS-1:0] grant;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk_i   (i_clk),
      .reset_i (i_reset),
      .raw_i   (i_button_raw[g]),
      .strobe_o(strobe[g]),
      .level_o (level[g])
    );
  end

  // Two's-complement trick isolates the lowest set pending bit.
  always_comb begin
    if (ONE_HOT_PULSE != 0) begin
      grant = pending_q & (~pending_q + NUM_BUTTONS'(1));
    end else begin
      grant = pending_q;
    end
    pending_d = (pending_q & ~grant) | strobe;
    pulse_d   = grant;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pending_q <= '0;
      pulse_q   <= '0;
    end else begin
      pending_q <= pending_d;
      pulse_q   <= pulse_d;
    end
  end

  assign o_button_pulse = pulse_q;
  assign o_button_level = level;

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Directed bench: one-hot (dut_a) and pass-through (dut_b) instances share stimulus.
module tb_button_debounce_pulse;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] raw;
  logic [1:0] pa, la, pb, lb;
  int         errors = 0;
  int         checks = 0;
  int         npulse;

  always #5 clk = ~clk;

  button_debounce_pulse #(
    .NUM_BUTTONS(2), .DEBOUNCE_CYCLES(4), .ONE_HOT_PULSE(1)
  ) dut_a (
    .i_clk(clk), .i_reset(rst), .i_button_raw(raw),
    .o_button_pulse(pa), .o_button_level(la)
  );

  button_debounce_pulse #(
    .NUM_BUTTONS(2), .DEBOUNCE_CYCLES(4), .ONE_HOT_PULSE(0)
  ) dut_b (
    .i_clk(clk), .i_reset(rst), .i_button_raw(raw),
    .o_button_pulse(pb), .o_button_level(lb)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n edges, counting any pulse seen on either instance.
  task automatic tick_count(input int n, inout int cnt);
    repeat (n) begin
      tick(1);
      if (pa != 2'b00) cnt++;
      if (pb != 2'b00) cnt++;
    end
  endtask

  initial begin
    rst = 1'b1;
    raw = 2'b00;
    tick(2);
    chk("reset_pulse_a", {6'd0, pa}, 8'h00);
    chk("reset_level_a", {6'd0, la}, 8'h00);
    chk("reset_pulse_b", {6'd0, pb}, 8'h00);
    chk("reset_level_b", {6'd0, lb}, 8'h00);
    rst = 1'b0;
    tick(3);

    // Clean press: raw[0] sampled high at edge N.
    raw = 2'b01;
    tick(1);
    tick(5);
    chk("clean_n5_pulse", {6'd0, pa}, 8'h00);
    tick(1);
    chk("clean_n6_pulse", {6'd0, pa}, 8'h00);
    tick(1);
    chk("clean_n7_pulse_a", {6'd0, pa}, 8'h01);
    chk("clean_n7_pulse_b", {6'd0, pb}, 8'h01);
    chk("clean_n7_level", {6'd0, la}, 8'h01);
    tick(1);
    chk("clean_n8_pulse", {6'd0, pa}, 8'h00);
    npulse = 0;
    tick_count(15, npulse);
    chk("clean_hold_no_repeat", npulse[7:0], 8'd0);
    chk("clean_hold_level", {6'd0, la}, 8'h01);
    raw = 2'b00;
    tick(12);
    chk("clean_released_level", {6'd0, la}, 8'h00);

    // Press bounce 1,0,1,1,0 then stable 1 from edge M.
    npulse = 0;
    raw = 2'b01; tick_count(1, npulse);
    raw = 2'b00; tick_count(1, npulse);
    raw = 2'b01; tick_count(1, npulse);
    raw = 2'b01; tick_count(1, npulse);
    raw = 2'b00; tick_count(1, npulse);
    raw = 2'b01; tick_count(1, npulse);
    tick_count(6, npulse);
    chk("bounce_no_early_pulse", npulse[7:0], 8'd0);
    tick(1);
    chk("bounce_m7_pulse", {6'd0, pa}, 8'h01);
    chk("bounce_m7_level", {6'd0, la}, 8'h01);
    tick(1);
    chk("bounce_m8_pulse", {6'd0, pa}, 8'h00);
    tick(4);

    // Release bounce 0,0,1 then stable 0 from edge R.
    npulse = 0;
    raw = 2'b00; tick_count(1, npulse);
    raw = 2'b00; tick_count(1, npulse);
    raw = 2'b01; tick_count(1, npulse);
    raw = 2'b00; tick_count(1, npulse);
    tick_count(5, npulse);
    chk("rel_r5_level", {6'd0, la}, 8'h01);
    tick_count(2, npulse);
    chk("rel_r7_level", {6'd0, la}, 8'h00);
    tick_count(8, npulse);
    chk("rel_no_second_pulse", npulse[7:0], 8'd0);

    // Simultaneous press on both channels at edge N.
    raw = 2'b11;
    tick(1);
    tick(6);
    chk("simul_n6_pulse_a", {6'd0, pa}, 8'h00);
    chk("simul_n6_pulse_b", {6'd0, pb}, 8'h00);
    tick(1);
    chk("simul_n7_pulse_a", {6'd0, pa}, 8'h01);
    chk("simul_n7_pulse_b", {6'd0, pb}, 8'h03);
    tick(1);
    chk("simul_n8_pulse_a", {6'd0, pa}, 8'h02);
    chk("simul_n8_pulse_b", {6'd0, pb}, 8'h00);
    tick(1);
    chk("simul_n9_pulse_a", {6'd0, pa}, 8'h00);
    chk("simul_level_b", {6'd0, lb}, 8'h03);
    raw = 2'b00;
    tick(12);
    chk("simul_released", {4'd0, la, lb}, 8'h00);

    // Reset mid-count: raw[1] high from edge N, reset at edge N+4.
    raw = 2'b10;
    tick(1);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_pulse", {4'd0, pa, pb}, 8'h00);
    chk("midrst_level", {4'd0, la, lb}, 8'h00);
    npulse = 0;
    tick_count(7, npulse);
    chk("midrst_no_early_pulse", npulse[7:0], 8'd0);
    tick(1);
    chk("midrst_n12_pulse_a", {6'd0, pa}, 8'h02);
    chk("midrst_n12_pulse_b", {6'd0, pb}, 8'h02);
    tick(1);
    chk("midrst_n13_pulse_a", {6'd0, pa}, 8'h00);
    npulse = 0;
    tick_count(10, npulse);
    chk("midrst_single_pulse", npulse[7:0], 8'd0);
    chk("midrst_level", {6'd0, la}, 8'h02);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
